ervp_loop_nest_sequencer: RTL and testbench

//  Three-level loop-nest sequencer. Drives index/address counters for a BNN tile

---
 rtl/ervp_loop_nest_sequencer_pkg.sv | 17 +
 rtl/ervp_loop_level_counter.sv | 44 ++++
 rtl/ervp_loop_nest_sequencer.sv | 146 ++++++++++++++
 tb/tb_ervp_loop_nest_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ervp_loop_nest_sequencer_pkg.sv
// Shared definitions for the three-level loop-nest sequencer.
package ervp_loop_nest_sequencer_pkg;

  localparam int NUM_LEVEL    = 3;
  localparam int BW_LNS_STATE = 2;

  // state    | meaning
  // LNS_IDLE | waiting for start; counters parked
  // LNS_RUN  | presenting beats; advance on out_valid & out_ready
  // LNS_DONE | one-cycle completion; done asserted here
  typedef enum logic [BW_LNS_STATE-1:0] {
    LNS_IDLE = 2'd0,
    LNS_RUN  = 2'd1,
    LNS_DONE = 2'd2
  } lns_state_e;

endpackage

// File: rtl/ervp_loop_level_counter.sv
// One loop level: index register with its own latched bound.
// carry_out tells the next outer level to advance.
module ervp_loop_level_counter #(
  parameter int BW_INDEX = 16
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                load,
  input  logic                clear,
  input  logic [BW_INDEX-1:0] bound_in,
  input  logic                inc,
  output logic [BW_INDEX-1:0] index,
  output logic                is_last,
  output logic                carry_out
);

  logic [BW_INDEX-1:0] bound_q;

  // A zero bound never matches here; the top never runs a walk with one.
  assign is_last   = (index == (bound_q - BW_INDEX'(1)));
  assign carry_out = inc & is_last;

  // Bound is captured once per walk so config writes mid-walk have no effect.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      bound_q <= '0;
    end else if (load) begin
      bound_q <= bound_in;
    end
  end

  // Index restarts on load/abort and wraps to zero when the level completes.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      index <= '0;
    end else if (load || clear) begin
      index <= '0;
    end else if (inc) begin
      if (is_last) index <= '0;
      else         index <= index + BW_INDEX'(1);
    end
  end

endmodule

// File: rtl/ervp_loop_nest_sequencer.sv
// Three-level loop-nest sequencer: emits (i0,i1,i2) and a linear address per
// accepted beat, i0 innermost. Addresses are built incrementally from
// row-start registers, so no multipliers are needed.
module ervp_loop_nest_sequencer
  import ervp_loop_nest_sequencer_pkg::*;
#(
  parameter int BW_INDEX = 16,
  parameter int BW_ADDR  = 32
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                start,
  input  logic                abort,
  input  logic [BW_ADDR-1:0]  cfg_base,
  input  logic [BW_INDEX-1:0] cfg_bound0,
  input  logic [BW_INDEX-1:0] cfg_bound1,
  input  logic [BW_INDEX-1:0] cfg_bound2,
  input  logic [BW_ADDR-1:0]  cfg_stride0,
  input  logic [BW_ADDR-1:0]  cfg_stride1,
  input  logic [BW_ADDR-1:0]  cfg_stride2,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BW_INDEX-1:0] out_index0,
  output logic [BW_INDEX-1:0] out_index1,
  output logic [BW_INDEX-1:0] out_index2,
  output logic [BW_ADDR-1:0]  out_addr,
  output logic                out_first,
  output logic                out_last
);

  lns_state_e         state;
  logic [BW_ADDR-1:0] stride0_q, stride1_q, stride2_q;
  logic [BW_ADDR-1:0] row1_q, row2_q, addr_q;
  logic [BW_ADDR-1:0] row1_next, row2_next;

  logic launch, accept, ctr_clear, any_zero_bound;
  logic last0, last1, last2;
  logic carry0, carry1, carry2;

  assign any_zero_bound = (cfg_bound0 == '0) || (cfg_bound1 == '0) || (cfg_bound2 == '0);
  assign launch    = (state == LNS_IDLE) && start && !abort;
  assign accept    = (state == LNS_RUN) && out_ready && !abort;
  assign ctr_clear = abort && (state != LNS_IDLE);
  assign row1_next = row1_q + stride1_q;
  assign row2_next = row2_q + stride2_q;

  ervp_loop_level_counter #(.BW_INDEX(BW_INDEX)) u_level0 (
    .clk       (clk),
    .rstnn     (rstnn),
    .load      (launch),
    .clear     (ctr_clear),
    .bound_in  (cfg_bound0),
    .inc       (accept),
    .index     (out_index0),
    .is_last   (last0),
    .carry_out (carry0)
  );

  ervp_loop_level_counter #(.BW_INDEX(BW_INDEX)) u_level1 (
    .clk       (clk),
    .rstnn     (rstnn),
    .load      (launch),
    .clear     (ctr_clear),
    .bound_in  (cfg_bound1),
    .inc       (carry0),
    .index     (out_index1),
    .is_last   (last1),
    .carry_out (carry1)
  );

  ervp_loop_level_counter #(.BW_INDEX(BW_INDEX)) u_level2 (
    .clk       (clk),
    .rstnn     (rstnn),
    .load      (launch),
    .clear     (ctr_clear),
    .bound_in  (cfg_bound2),
    .inc       (carry1),
    .index     (out_index2),
    .is_last   (last2),
    .carry_out (carry2)
  );

  // FSM plus stride latches and address/row-start registers.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state     <= LNS_IDLE;
      stride0_q <= '0;
      stride1_q <= '0;
      stride2_q <= '0;
      row1_q    <= '0;
      row2_q    <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        LNS_IDLE: begin
          if (launch) begin
            stride0_q <= cfg_stride0;
            stride1_q <= cfg_stride1;
            stride2_q <= cfg_stride2;
            row1_q    <= cfg_base;
            row2_q    <= cfg_base;
            addr_q    <= cfg_base;
            state     <= any_zero_bound ? LNS_DONE : LNS_RUN;
          end
        end
        LNS_RUN: begin
          if (abort) begin
            addr_q <= '0;
            state  <= LNS_IDLE;
          end else if (accept) begin
            if (!carry0) begin
              addr_q <= addr_q + stride0_q;
            end else if (!carry1) begin
              row1_q <= row1_next;
              addr_q <= row1_next;
            end else if (!carry2) begin
              row2_q <= row2_next;
              row1_q <= row2_next;
              addr_q <= row2_next;
            end else begin
              state <= LNS_DONE;
            end
          end
        end
        LNS_DONE: begin
          state <= LNS_IDLE;
        end
        default: begin
          state <= LNS_IDLE;
        end
      endcase
    end
  end

  // Status and beat qualifiers derived from the registered state and indices.
  assign busy      = (state != LNS_IDLE);
  assign out_valid = (state == LNS_RUN);
  // An abort arriving in the DONE cycle swallows the pulse.
  assign done      = (state == LNS_DONE) && !abort;
  assign out_addr  = addr_q;
  assign out_first = out_valid && (out_index0 == '0) && (out_index1 == '0) && (out_index2 == '0);
  assign out_last  = out_valid && last0 && last1 && last2;

endmodule

// File: tb/tb_ervp_loop_nest_sequencer.sv
module tb_ervp_loop_nest_sequencer;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_bound0 = '0, cfg_bound1 = '0, cfg_bound2 = '0;
  logic [31:0] cfg_stride0 = '0, cfg_stride1 = '0, cfg_stride2 = '0;
  logic        busy, done, out_valid, out_first, out_last;
  logic        out_ready = 1'b1;
  logic [15:0] out_index0, out_index1, out_index2;
  logic [31:0] out_addr;

  int total = 0;
  int bad   = 0;

  ervp_loop_nest_sequencer #(.BW_INDEX(16), .BW_ADDR(32)) dut (
    .clk         (clk),
    .rstnn       (rstnn),
    .start       (start),
    .abort       (abort),
    .cfg_base    (cfg_base),
    .cfg_bound0  (cfg_bound0),
    .cfg_bound1  (cfg_bound1),
    .cfg_bound2  (cfg_bound2),
    .cfg_stride0 (cfg_stride0),
    .cfg_stride1 (cfg_stride1),
    .cfg_stride2 (cfg_stride2),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index0  (out_index0),
    .out_index1  (out_index1),
    .out_index2  (out_index2),
    .out_addr    (out_addr),
    .out_first   (out_first),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] b, input logic [31:0] s0,
                                             input logic [31:0] s1, input logic [31:0] s2,
                                             input int i0, input int i1, input int i2);
    return b + s0 * 32'(i0) + s1 * 32'(i1) + s2 * 32'(i2);
  endfunction

  task automatic chk_beat(input string tag, input int i0, input int i1, input int i2,
                          input logic [31:0] addr, input logic first, input logic last);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_i0"}, {16'd0, out_index0}, 32'(i0));
    chk({tag, "_i1"}, {16'd0, out_index1}, 32'(i1));
    chk({tag, "_i2"}, {16'd0, out_index2}, 32'(i2));
    chk({tag, "_addr"}, out_addr, addr);
    chk({tag, "_first"}, {31'd0, out_first}, {31'd0, first});
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  task automatic start_walk(input logic [31:0] b, input int b0, input int b1, input int b2,
                            input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    cfg_base = b;
    cfg_bound0 = 16'(b0); cfg_bound1 = 16'(b1); cfg_bound2 = 16'(b2);
    cfg_stride0 = s0; cfg_stride1 = s1; cfg_stride2 = s2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks the full nest; optionally holds ready low for one cycle per beat.
  task automatic run_walk(input string tag, input int b0, input int b1, input int b2,
                          input logic [31:0] b, input logic [31:0] s0,
                          input logic [31:0] s1, input logic [31:0] s2, input bit toggle);
    int n;
    n = 0;
    for (int i2 = 0; i2 < b2; i2++)
      for (int i1 = 0; i1 < b1; i1++)
        for (int i0 = 0; i0 < b0; i0++) begin
          logic [31:0] ea;
          logic ef, el;
          ea = model_addr(b, s0, s1, s2, i0, i1, i2);
          ef = (i0 == 0) && (i1 == 0) && (i2 == 0);
          el = (i0 == b0 - 1) && (i1 == b1 - 1) && (i2 == b2 - 1);
          chk_beat($sformatf("%s_b%0d", tag, n), i0, i1, i2, ea, ef, el);
          if (toggle) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk_beat($sformatf("%s_hold%0d", tag, n), i0, i1, i2, ea, ef, el);
            out_ready = 1'b1;
          end
          @(negedge clk);
          n++;
        end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_after_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_first", {31'd0, out_first}, 32'd0);
    chk("rst_idx", {out_index0, out_index1}, 32'd0);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);

    // basic walk, ready always high
    out_ready = 1'b1;
    start_walk(32'h1000, 2, 3, 2, 32'd4, 32'd16, 32'd100);
    run_walk("w1", 2, 3, 2, 32'h1000, 32'd4, 32'd16, 32'd100, 1'b0);

    // same walk, ready toggling
    start_walk(32'h1000, 2, 3, 2, 32'd4, 32'd16, 32'd100);
    run_walk("w2", 2, 3, 2, 32'h1000, 32'd4, 32'd16, 32'd100, 1'b1);

    // empty nest
    start_walk(32'h1000, 0, 3, 2, 32'd4, 32'd16, 32'd100);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_busy", {31'd0, busy}, 32'd1);
    chk("empty_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("empty_done_off", {31'd0, done}, 32'd0);
    chk("empty_busy_off", {31'd0, busy}, 32'd0);
    chk("empty_valid_off", {31'd0, out_valid}, 32'd0);

    // negative stride wraps
    start_walk(32'h4, 3, 1, 1, 32'hFFFF_FFFC, 32'd8, 32'd8);
    chk_beat("wrap0", 0, 0, 0, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    chk_beat("wrap1", 1, 0, 0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("wrap2", 2, 0, 0, 32'hFFFF_FFFC, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // abort on the fifth beat, then a one-beat walk
    start_walk(32'h1000, 2, 3, 2, 32'd4, 32'd16, 32'd100);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk_beat("ab_b4", 0, 2, 0, 32'h1020, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("ab_done2", {31'd0, done}, 32'd0);
    start_walk(32'h2000, 1, 1, 1, 32'd4, 32'd16, 32'd100);
    chk_beat("one_b0", 0, 0, 0, 32'h2000, 1'b1, 1'b1);
    @(negedge clk);
    chk("one_done", {31'd0, done}, 32'd1);
    chk("one_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("one_idle", {31'd0, busy}, 32'd0);

    // start while busy is ignored, then reset mid-walk
    start_walk(32'h1000, 2, 3, 2, 32'd4, 32'd16, 32'd100);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk_beat("busy_b3", 1, 1, 0, 32'h1014, 1'b0, 1'b0);
    out_ready = 1'b0;
    cfg_base = 32'h5000;
    cfg_stride0 = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_beat("busy_restart", 1, 1, 0, 32'h1014, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("busy_b4", 0, 2, 0, 32'h1020, 1'b0, 1'b0);
    #2;
    rstnn = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_addr", out_addr, 32'd0);
    chk("mr_idx", {out_index2, out_index1}, 32'd0);
    chk("mr_first_last", {30'd0, out_first, out_last}, 32'd0);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    chk("mr_idle", {31'd0, busy}, 32'd0);
    chk("mr_nodone", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
